register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank_pkg.sv | 14 +
 rtl/reg_cell.sv | 29 ++
 rtl/register_bank.sv | 105 ++++++++++
 tb/tb_register_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// Shared CPU constants for the register bank: data width, register count, stack-pointer
// index, reset value and step.
package register_bank_pkg;

    localparam int unsigned CpuWidth   = 16;
    localparam int unsigned CpuNregs   = 10;
    localparam int unsigned CpuSpIdx   = 1;
    localparam logic [15:0] CpuSpReset = 16'hFFFE;
    localparam int unsigned CpuSpStep  = 2;

    // Fixed address-port width, independent of WIDTH.
    localparam int unsigned CpuAddrW   = 4;

endpackage

// File: rtl/reg_cell.sv
// Single WIDTH-bit register with load enable and a synchronous reset value.
module reg_cell #(
    parameter int unsigned         WIDTH     = 16,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] val_q, val_d;

    always_comb begin
        val_d = load_i ? d_i : val_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            val_q <= RESET_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/register_bank.sv
// Ten-entry register bank: r0 hard-wired to zero, r1 doubles as a stack pointer with
// inc/dec and wrap detection, r2..r9 are plain registers. Sticky flag for bad write indices.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int unsigned      WIDTH    = CpuWidth,
    parameter int unsigned      NREGS    = CpuNregs,
    parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(CpuSpReset),
    parameter int unsigned      SP_STEP  = CpuSpStep
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [CpuAddrW-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic                sp_inc,
    input  logic                sp_dec,
    output logic [WIDTH-1:0]    r0,
    output logic [WIDTH-1:0]    r1,
    output logic [WIDTH-1:0]    r2,
    output logic [WIDTH-1:0]    r3,
    output logic [WIDTH-1:0]    r4,
    output logic [WIDTH-1:0]    r5,
    output logic [WIDTH-1:0]    r6,
    output logic [WIDTH-1:0]    r7,
    output logic [WIDTH-1:0]    r8,
    output logic [WIDTH-1:0]    r9,
    output logic                bad_addr,
    output logic                sp_wrap
);

    logic [WIDTH-1:0] gpr [2:9];

    logic [WIDTH-1:0] sp_q, sp_d;
    logic             bad_q, bad_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   sp_sum, sp_diff;
    logic             sp_write;

    for (genvar i = 2; i <= 9; i++) begin : g_cell
        // Indices at or above NREGS are not architectural and never load.
        logic load;
        assign load = we && (waddr == CpuAddrW'(i)) && (i < NREGS);

        reg_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL ('0)
        ) u_cell (
            .clk_i   (clk),
            .reset_i (reset),
            .load_i  (load),
            .d_i     (wdata),
            .q_o     (gpr[i])
        );
    end

    assign sp_write = we && (waddr == CpuAddrW'(CpuSpIdx));
    assign sp_sum   = {1'b0, sp_q} + (WIDTH + 1)'(SP_STEP);
    assign sp_diff  = {1'b0, sp_q} - (WIDTH + 1)'(SP_STEP);

    always_comb begin
        sp_d   = sp_q;
        wrap_d = 1'b0;
        bad_d  = bad_q;
        // A direct write to r1 wins over any stack adjustment in the same cycle.
        if (sp_write) begin
            sp_d = wdata;
        end else if (sp_inc && !sp_dec) begin
            sp_d   = sp_sum[WIDTH-1:0];
            wrap_d = sp_sum[WIDTH];
        end else if (sp_dec && !sp_inc) begin
            sp_d   = sp_diff[WIDTH-1:0];
            wrap_d = sp_diff[WIDTH];
        end
        if (we && (32'(waddr) >= NREGS)) begin
            bad_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q   <= SP_RESET;
            bad_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            bad_q  <= bad_d;
            wrap_q <= wrap_d;
        end
    end

    assign r0       = '0;
    assign r1       = sp_q;
    assign r2       = gpr[2];
    assign r3       = gpr[3];
    assign r4       = gpr[4];
    assign r5       = gpr[5];
    assign r6       = gpr[6];
    assign r7       = gpr[7];
    assign r8       = gpr[8];
    assign r9       = gpr[9];
    assign bad_addr = bad_q;
    assign sp_wrap  = wrap_q;

endmodule

// File: tb/tb_register_bank.sv
// Randomised and directed checks of register_bank against an arithmetic reference model.
module tb_register_bank;

    logic        clk = 1'b0;
    logic        reset, we, sp_inc, sp_dec;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9;
    logic        bad_addr, sp_wrap;
    logic [15:0] dut_r [10];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference state.
    int m_reg [10];
    int m_bad;
    int m_wrap;

    register_bank u_dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .sp_inc   (sp_inc),
        .sp_dec   (sp_dec),
        .r0       (r0),
        .r1       (r1),
        .r2       (r2),
        .r3       (r3),
        .r4       (r4),
        .r5       (r5),
        .r6       (r6),
        .r7       (r7),
        .r8       (r8),
        .r9       (r9),
        .bad_addr (bad_addr),
        .sp_wrap  (sp_wrap)
    );

    always #5 clk = ~clk;

    assign dut_r[0] = r0;
    assign dut_r[1] = r1;
    assign dut_r[2] = r2;
    assign dut_r[3] = r3;
    assign dut_r[4] = r4;
    assign dut_r[5] = r5;
    assign dut_r[6] = r6;
    assign dut_r[7] = r7;
    assign dut_r[8] = r8;
    assign dut_r[9] = r9;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference update from the architectural rules for one rising edge.
    task automatic model_edge(input bit rst, input bit w, input int a, input int d,
                              input bit inc, input bit dec);
        int t;
        if (rst) begin
            for (int i = 0; i < 10; i++) m_reg[i] = 0;
            m_reg[1] = 'hFFFE;
            m_bad    = 0;
            m_wrap   = 0;
            return;
        end
        m_wrap = 0;
        if (w && a >= 10) m_bad = 1;
        if (w && a == 1) begin
            m_reg[1] = d;
        end else if (inc && !dec) begin
            t        = m_reg[1] + 2;
            m_wrap   = (t > 65535) ? 1 : 0;
            m_reg[1] = t % 65536;
        end else if (dec && !inc) begin
            t        = m_reg[1] - 2;
            m_wrap   = (t < 0) ? 1 : 0;
            m_reg[1] = (t + 65536) % 65536;
        end
        if (w && a >= 2 && a <= 9) m_reg[a] = d;
    endtask

    task automatic check_all();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("r%0d", i), 32'(dut_r[i]), 32'(m_reg[i]));
        end
        check("bad_addr", 32'(bad_addr), 32'(m_bad));
        check("sp_wrap", 32'(sp_wrap), 32'(m_wrap));
    endtask

    task automatic step(input bit rst, input bit w, input int a, input int d,
                        input bit inc, input bit dec);
        reset  = rst;
        we     = w;
        waddr  = 4'(a);
        wdata  = 16'(d);
        sp_inc = inc;
        sp_dec = dec;
        @(posedge clk);
        model_edge(rst, w, a, d, inc, dec);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int a, d, sel;
        bit w, inc, dec, rst;

        for (int i = 0; i < 10; i++) m_reg[i] = 0;
        m_bad  = 0;
        m_wrap = 0;
        reset  = 1'b1;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        sp_inc = 1'b0;
        sp_dec = 1'b0;
        #1;

        // Reset then idle.
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        idle();
        check("sp_after_reset", 32'(r1), 32'h0000_FFFE);

        // Normal write, then write to r0 is discarded.
        step(1'b0, 1'b1, 5, 'h1234, 1'b0, 1'b0);
        check("r5_write", 32'(r5), 32'h0000_1234);
        step(1'b0, 1'b1, 0, 'hBEEF, 1'b0, 1'b0);
        check("r0_zero", 32'(r0), 32'h0);
        check("r0_no_bad", 32'(bad_addr), 32'h0);

        // Out-of-range write sets a sticky flag.
        step(1'b0, 1'b1, 12, 'h5555, 1'b0, 1'b0);
        check("bad_set", 32'(bad_addr), 32'h1);
        for (int i = 0; i < 10; i++) idle();
        check("bad_sticky", 32'(bad_addr), 32'h1);

        // Wrap up through 0xFFFF then back down.
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        check("inc_wrap_val", 32'(r1), 32'h0);
        check("inc_wrap_flag", 32'(sp_wrap), 32'h1);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        check("dec_wrap_val", 32'(r1), 32'h0000_FFFE);
        check("dec_wrap_flag", 32'(sp_wrap), 32'h1);
        idle();
        check("wrap_pulse_end", 32'(sp_wrap), 32'h0);

        // Both inc and dec: no change, no pulse.
        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        check("inc_dec_hold", 32'(r1), 32'h0000_FFFE);

        // Write priority on r1, concurrent write elsewhere.
        step(1'b0, 1'b1, 1, 'h0100, 1'b0, 1'b1);
        check("sp_write_prio", 32'(r1), 32'h0000_0100);
        step(1'b0, 1'b1, 3, 'hA5A5, 1'b1, 1'b0);
        check("r3_concurrent", 32'(r3), 32'h0000_A5A5);
        check("sp_concurrent", 32'(r1), 32'h0000_0102);

        // Reset overrides write and inc.
        step(1'b0, 1'b1, 12, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 7, 'h7777, 1'b1, 1'b0);
        check("rst_r7", 32'(r7), 32'h0);
        check("rst_sp", 32'(r1), 32'h0000_FFFE);
        check("rst_bad", 32'(bad_addr), 32'h0);

        // Random traffic, biased toward stack-pointer boundary values.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            w   = ($urandom_range(0, 2) == 0);
            a   = $urandom_range(0, 15);
            if (w && $urandom_range(0, 3) == 0) a = 1;
            sel = $urandom_range(0, 5);
            case (sel)
                0:       d = 0;
                1:       d = 1;
                2:       d = 'hFFFE;
                3:       d = 'hFFFF;
                default: d = int'($urandom_range(0, 65535));
            endcase
            inc = $urandom_range(0, 1);
            dec = $urandom_range(0, 1);
            step(rst, w, a, d, inc, dec);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
